exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage plus EXE/MEM pipeline register; sits directly downstream of the ID/EXE latch.
- Consumes ALU operands, ALU option and write-enable flags.
- Single-cycle ops resolve combinationally and register into the MEM stage; multiply/divide run on an iterative engine.
- Iterative ops assert exe_stall so upstream latches and PC hold until the result is ready.

Parameters:
DATA_WIDTH, 32, operand/result width; power of two, at least 8
ALU_OPTION_WIDTH, 5, width of ALU option code

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
cpu_en  input  1  global enable; low freezes all state
EXE_ALU_A  input  DATA_WIDTH  operand A
EXE_ALU_B  input  DATA_WIDTH  operand B / store data
EXE_ALU_option  input  ALU_OPTION_WIDTH  operation code
EXE_is_write_MEM_future  input  1  instruction writes memory
EXE_is_write_regs_future  input  1  instruction writes register file
MEM_ALU_result  output  DATA_WIDTH  registered result
MEM_store_data  output  DATA_WIDTH  registered copy of operand B
MEM_is_write_MEM_future  output  1  registered flag
MEM_is_write_regs_future  output  1  registered flag
exe_stall  output  1  combinational; high = upstream must hold

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- On rst assertion, independent of clk:
  - FSM goes to IDLE; iteration counter and engine registers clear to 0.
  - All MEM_* outputs clear to 0; exe_stall reads 0.
- cpu_en=0: no register changes and FSM frozen; exe_stall keeps its current value.
- Option codes (shift amount = low log2(DATA_WIDTH) bits of B):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1).
  - 10 MUL (low half), 11 MULHU (unsigned high half), 12 DIVU (quotient), 13 REMU (remainder).
  - Any other code: result 0, flags still pass through.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- Single-cycle ops (0-9, undefined codes, and 12/13 with B=0), in IDLE:
  - exe_stall=0.
  - Next enabled edge loads result, B and both flags into MEM_*; latency 1 cycle.
- Divide by zero:
  - DIVU gives all ones; REMU gives A.
  - Handled as single-cycle; the engine is not started.
- FSM states IDLE, BUSY, DONE, with multi-cycle op m = 10-13 and B!=0:
  - IDLE + m: exe_stall=1. The edge captures A, B and the op into the engine, clears the counter and moves to BUSY. MEM_* load a bubble: result 0, both flags 0, store data 0.
  - BUSY: exe_stall=1. One iteration per enabled edge: shift-add for MUL/MULHU, restoring shift-subtract for DIVU/REMU. After DATA_WIDTH iterations, go to DONE. MEM_* load a bubble each edge.
  - DONE: exe_stall=0. The edge loads the engine result, plus the current EXE_ALU_B and flags (still held by upstream), into MEM_*. FSM returns to IDLE unconditionally and never reissues the same instruction.
- Multi-cycle timing: stall is high for DATA_WIDTH+1 cycles; the result appears at MEM_* DATA_WIDTH+2 enabled edges after issue.
- Engine uses its captured operands only; EXE_* changes during BUSY are ignored.
- Reset mid-BUSY aborts the op with no partial result; the bench must not see a result for the aborted op.
- Flags never pass through to MEM_* while exe_stall=1, so no duplicate memory or register write occurs.

Test Plan:
- ADD A=0x00000005, B=0xFFFFFFFF, write_regs=1 -> one edge later MEM_ALU_result=0x00000004, MEM_is_write_regs_future=1, exe_stall never high.
- MUL A=7, B=6 held while stalled -> exe_stall high exactly 33 cycles; MEM flags 0 during stall; next edge MEM_ALU_result=42; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU A=100, B=7 -> 14 after 34 edges; REMU same operands -> 2; SRA A=0x80000000, B=0x21 -> 0xC0000000 (shamt 1).
- DIVU A=9, B=0 -> single cycle, result 0xFFFFFFFF, exe_stall 0; REMU A=9, B=0 -> 9.
- MUL 3*5 with cpu_en low for 4 cycles mid-BUSY -> counter and outputs frozen; stall lasts 37 cycles total; result 15.
- rst pulsed (not on an edge) at BUSY iteration 10 -> outputs 0 immediately, exe_stall 0; following ADD 1+1 -> result 2 next edge.

Source files
------------

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage with iterative mul/div engine and EXE/MEM register
module exe_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_OPTION_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_en,
  input  logic [DATA_WIDTH-1:0]       EXE_ALU_A,
  input  logic [DATA_WIDTH-1:0]       EXE_ALU_B,
  input  logic [ALU_OPTION_WIDTH-1:0] EXE_ALU_option,
  input  logic                        EXE_is_write_MEM_future,
  input  logic                        EXE_is_write_regs_future,
  output logic [DATA_WIDTH-1:0]       MEM_ALU_result,
  output logic [DATA_WIDTH-1:0]       MEM_store_data,
  output logic                        MEM_is_write_MEM_future,
  output logic                        MEM_is_write_regs_future,
  output logic                        exe_stall
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [ALU_OPTION_WIDTH-1:0] OP_ADD   = ALU_OPTION_WIDTH'(0);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SUB   = ALU_OPTION_WIDTH'(1);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_AND   = ALU_OPTION_WIDTH'(2);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_OR    = ALU_OPTION_WIDTH'(3);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_XOR   = ALU_OPTION_WIDTH'(4);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SLL   = ALU_OPTION_WIDTH'(5);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SRL   = ALU_OPTION_WIDTH'(6);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SRA   = ALU_OPTION_WIDTH'(7);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SLT   = ALU_OPTION_WIDTH'(8);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_SLTU  = ALU_OPTION_WIDTH'(9);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_MUL   = ALU_OPTION_WIDTH'(10);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_MULHU = ALU_OPTION_WIDTH'(11);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_DIVU  = ALU_OPTION_WIDTH'(12);
  localparam logic [ALU_OPTION_WIDTH-1:0] OP_REMU  = ALU_OPTION_WIDTH'(13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  eng_div_q, eng_div_d;
  logic                  eng_high_q, eng_high_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] store_q, store_d;
  logic                  wm_q, wm_d;
  logic                  wr_q, wr_d;

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  is_mul, is_div, is_multi;
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH-1:0] div_diff;
  logic                  div_ge;

  assign is_mul   = (EXE_ALU_option == OP_MUL) || (EXE_ALU_option == OP_MULHU);
  assign is_div   = (EXE_ALU_option == OP_DIVU) || (EXE_ALU_option == OP_REMU);
  // A zero B turns every mul/div into a trivially known result, so only B!=0 uses the engine.
  assign is_multi = (is_mul || is_div) && (EXE_ALU_B != '0);

  // Single-cycle ALU; MUL/MULHU only land here with B=0, where the answer is 0.
  always_comb begin
    shamt   = EXE_ALU_B[SHW-1:0];
    alu_res = '0;
    case (EXE_ALU_option)
      OP_ADD:  alu_res = EXE_ALU_A + EXE_ALU_B;
      OP_SUB:  alu_res = EXE_ALU_A - EXE_ALU_B;
      OP_AND:  alu_res = EXE_ALU_A & EXE_ALU_B;
      OP_OR:   alu_res = EXE_ALU_A | EXE_ALU_B;
      OP_XOR:  alu_res = EXE_ALU_A ^ EXE_ALU_B;
      OP_SLL:  alu_res = EXE_ALU_A << shamt;
      OP_SRL:  alu_res = EXE_ALU_A >> shamt;
      OP_SRA:  alu_res = $signed(EXE_ALU_A) >>> shamt;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(EXE_ALU_A) < $signed(EXE_ALU_B))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (EXE_ALU_A < EXE_ALU_B)};
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = EXE_ALU_A;
      default: alu_res = '0;
    endcase
  end

  // FSM next state, engine iteration and EXE/MEM register loading.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    eng_div_d  = eng_div_q;
    eng_high_d = eng_high_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_d      = res_q;
    store_d    = store_q;
    wm_d       = wm_q;
    wr_d       = wr_q;
    exe_stall  = 1'b0;

    // Shift-add: {hi,lo} holds partial product over the remaining multiplier bits.
    mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
    // Restoring divide: hi is the running remainder, lo shifts dividend out and quotient in.
    div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[DATA_WIDTH-1:0] - opnd_q;

    case (state_q)
      S_IDLE: begin
        if (is_multi) begin
          exe_stall  = 1'b1;
          state_d    = S_BUSY;
          cnt_d      = '0;
          eng_div_d  = is_div;
          eng_high_d = (EXE_ALU_option == OP_MULHU) || (EXE_ALU_option == OP_REMU);
          hi_d       = '0;
          opnd_d     = is_div ? EXE_ALU_B : EXE_ALU_A;
          lo_d       = is_div ? EXE_ALU_A : EXE_ALU_B;
          res_d      = '0;
          store_d    = '0;
          wm_d       = 1'b0;
          wr_d       = 1'b0;
        end else begin
          res_d   = alu_res;
          store_d = EXE_ALU_B;
          wm_d    = EXE_is_write_MEM_future;
          wr_d    = EXE_is_write_regs_future;
        end
      end
      S_BUSY: begin
        exe_stall = 1'b1;
        if (eng_div_q) begin
          hi_d = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
          lo_d = {lo_q[DATA_WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[DATA_WIDTH:1];
          lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = S_DONE;
        end
        res_d   = '0;
        store_d = '0;
        wm_d    = 1'b0;
        wr_d    = 1'b0;
      end
      S_DONE: begin
        res_d   = eng_high_q ? hi_q : lo_q;
        store_d = EXE_ALU_B;
        wm_d    = EXE_is_write_MEM_future;
        wr_d    = EXE_is_write_regs_future;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An in-flight op is being aborted; upstream must not be told to hold.
    if (rst) begin
      exe_stall = 1'b0;
    end
  end

  // State registers; cpu_en low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      eng_div_q  <= 1'b0;
      eng_high_q <= 1'b0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_q      <= '0;
      store_q    <= '0;
      wm_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else if (cpu_en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      eng_div_q  <= eng_div_d;
      eng_high_q <= eng_high_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      res_q      <= res_d;
      store_q    <= store_d;
      wm_q       <= wm_d;
      wr_q       <= wr_d;
    end
  end

  assign MEM_ALU_result           = res_q;
  assign MEM_store_data           = store_q;
  assign MEM_is_write_MEM_future  = wm_q;
  assign MEM_is_write_regs_future = wr_q;

endmodule
